// File: rtl/mandelbrot_pkg.sv
// Shared types and fixed-point helpers for the Mandelbrot context engine.
// Latency: n/a (types, constants, pure functions).
// Backpressure: n/a.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } slot_state_t;

    localparam int DEF_DATA_WIDTH  = 25;
    localparam int DEF_FRACT_WIDTH = 20;
    localparam int DEF_ITER_WIDTH  = 8;
    localparam int DEF_PIXEL_WIDTH = 10;
    localparam int DEF_NUM_CTX     = 4;

    // Operand width of the shared multiplier; instances sign-extend into it.
    localparam int FX_W = 32;

    localparam longint ESCAPE_SQ = longint'(4) << DEF_FRACT_WIDTH;

    function automatic logic signed [2*FX_W-1:0] fx_mul(
        input logic signed [FX_W-1:0] a,
        input logic signed [FX_W-1:0] b,
        input int                     fract
    );
        logic signed [2*FX_W-1:0] prod;
        prod = (2*FX_W)'(a) * (2*FX_W)'(b);
        return prod >>> fract;
    endfunction

endpackage

// File: rtl/mandelbrot_step.sv
// Two-stage z-update: stage 1 registers the squares/cross product, stage 2 decides escape and forms z_next.
// Latency: 1 cycle from a RUN visit to the write-back request for that slot.
// Backpressure: none; a RUN visit is always accepted, and clear drops the in-flight stage-1 entry.
module mandelbrot_step
    import mandelbrot_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int ITER_WIDTH  = DEF_ITER_WIDTH,
    parameter int NUM_CTX     = DEF_NUM_CTX,
    localparam int CTX_W      = $clog2(NUM_CTX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  run_vld,
    input  logic [CTX_W-1:0]      run_idx,
    input  logic [DATA_WIDTH-1:0] run_zr,
    input  logic [DATA_WIDTH-1:0] run_zi,
    output logic                  s1_vld,
    output logic [CTX_W-1:0]      s1_idx,
    input  logic [DATA_WIDTH-1:0] wb_cr,
    input  logic [DATA_WIDTH-1:0] wb_ci,
    input  logic [ITER_WIDTH-1:0] wb_iter_cur,
    input  logic [ITER_WIDTH-1:0] wb_iter_max,
    output logic                  wb_done,
    output logic                  wb_escaped,
    output logic [DATA_WIDTH-1:0] wb_zr,
    output logic [DATA_WIDTH-1:0] wb_zi,
    output logic [ITER_WIDTH-1:0] wb_iter
);

    // Two guard bits keep |z|^2 of an escaping z (up to ~8 per axis) from wrapping.
    localparam int MAG_W = DATA_WIDTH + 2;
    localparam int SUM_W = MAG_W + 1;
    localparam logic signed [SUM_W-1:0] ESC_LIM =
        SUM_W'((ESCAPE_SQ >>> DEF_FRACT_WIDTH) << FRACT_WIDTH);

    logic signed [FX_W-1:0]  zr_x;
    logic signed [FX_W-1:0]  zi_x;
    logic signed [MAG_W-1:0] s1_zr2;
    logic signed [MAG_W-1:0] s1_zi2;
    logic signed [MAG_W-1:0] s1_zrzi;
    logic signed [SUM_W-1:0] mag;
    logic signed [MAG_W-1:0] re_new;
    logic signed [MAG_W-1:0] im_new;

    always_comb begin
        zr_x = FX_W'($signed(run_zr));
        zi_x = FX_W'($signed(run_zi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_idx  <= '0;
            s1_zr2  <= '0;
            s1_zi2  <= '0;
            s1_zrzi <= '0;
        end else begin
            s1_vld <= run_vld & ~clear;
            if (run_vld) begin
                s1_idx  <= run_idx;
                s1_zr2  <= MAG_W'(fx_mul(zr_x, zr_x, FRACT_WIDTH));
                s1_zi2  <= MAG_W'(fx_mul(zi_x, zi_x, FRACT_WIDTH));
                s1_zrzi <= MAG_W'(fx_mul(zr_x, zi_x, FRACT_WIDTH));
            end
        end
    end

    // |z|^2 == 4.0 exactly stays bounded; only a strictly larger value escapes.
    always_comb begin
        mag        = SUM_W'(s1_zr2) + SUM_W'(s1_zi2);
        re_new     = s1_zr2 - s1_zi2 + MAG_W'($signed(wb_cr));
        im_new     = (s1_zrzi <<< 1) + MAG_W'($signed(wb_ci));
        wb_escaped = (mag > ESC_LIM);
        wb_done    = wb_escaped | (wb_iter_cur == wb_iter_max);
        wb_zr      = re_new[DATA_WIDTH-1:0];
        wb_zi      = im_new[DATA_WIDTH-1:0];
        wb_iter    = wb_iter_cur + ITER_WIDTH'(1);
    end

endmodule

// File: rtl/mandelbrot_ctx_engine.sv
// Multi-context Mandelbrot engine: NUM_CTX pixel slots visited round-robin through mandelbrot_step.
// Latency: out_valid rises NUM_CTX*(out_iter+2)+1 cycles after load when the output register is free.
// Backpressure: in_ready only when the visited slot is FREE; finished slots wait in DONE while out_valid & !out_ready.
module mandelbrot_ctx_engine
    import mandelbrot_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int ITER_WIDTH  = DEF_ITER_WIDTH,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int NUM_CTX     = DEF_NUM_CTX
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [ITER_WIDTH-1:0]  iter_max,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_cr,
    input  logic [DATA_WIDTH-1:0]  in_ci,
    input  logic [PIXEL_WIDTH-1:0] in_xpix,
    input  logic [PIXEL_WIDTH-1:0] in_ypix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ITER_WIDTH-1:0]  out_iter,
    output logic                   out_escaped,
    output logic [PIXEL_WIDTH-1:0] out_xpix,
    output logic [PIXEL_WIDTH-1:0] out_ypix,
    output logic                   busy
);

    localparam int CTX_W = $clog2(NUM_CTX);

    slot_state_t            slot_state [NUM_CTX];
    logic [DATA_WIDTH-1:0]  slot_zr    [NUM_CTX];
    logic [DATA_WIDTH-1:0]  slot_zi    [NUM_CTX];
    logic [DATA_WIDTH-1:0]  slot_cr    [NUM_CTX];
    logic [DATA_WIDTH-1:0]  slot_ci    [NUM_CTX];
    logic [ITER_WIDTH-1:0]  slot_iter  [NUM_CTX];
    logic [ITER_WIDTH-1:0]  slot_imax  [NUM_CTX];
    logic                   slot_esc   [NUM_CTX];
    logic [PIXEL_WIDTH-1:0] slot_xpix  [NUM_CTX];
    logic [PIXEL_WIDTH-1:0] slot_ypix  [NUM_CTX];

    logic [CTX_W-1:0]       ptr;
    logic                   load;
    logic                   run_vld;
    logic                   xfer;
    logic                   s1_vld;
    logic [CTX_W-1:0]       s1_idx;
    logic                   wb_done;
    logic                   wb_escaped;
    logic [DATA_WIDTH-1:0]  wb_zr;
    logic [DATA_WIDTH-1:0]  wb_zi;
    logic [ITER_WIDTH-1:0]  wb_iter;

    always_comb begin
        in_ready = (slot_state[ptr] == FREE) & ~clear;
        load     = in_valid & in_ready;
        run_vld  = (slot_state[ptr] == RUN);
        xfer     = (slot_state[ptr] == DONE) & (~out_valid | out_ready) & ~clear;
    end

    always_comb begin
        busy = out_valid;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (slot_state[i] != FREE) begin
                busy = 1'b1;
            end
        end
    end

    mandelbrot_step #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH),
        .ITER_WIDTH  (ITER_WIDTH),
        .NUM_CTX     (NUM_CTX)
    ) u_step (
        .clk         (clk),
        .rst         (reset),
        .clear       (clear),
        .run_vld     (run_vld),
        .run_idx     (ptr),
        .run_zr      (slot_zr[ptr]),
        .run_zi      (slot_zi[ptr]),
        .s1_vld      (s1_vld),
        .s1_idx      (s1_idx),
        .wb_cr       (slot_cr[s1_idx]),
        .wb_ci       (slot_ci[s1_idx]),
        .wb_iter_cur (slot_iter[s1_idx]),
        .wb_iter_max (slot_imax[s1_idx]),
        .wb_done     (wb_done),
        .wb_escaped  (wb_escaped),
        .wb_zr       (wb_zr),
        .wb_zi       (wb_zi),
        .wb_iter     (wb_iter)
    );

    // ptr and s1_idx always differ (NUM_CTX >= 2), so the visit and the write-back never hit the same slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            out_valid   <= 1'b0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            out_xpix    <= '0;
            out_ypix    <= '0;
            for (int i = 0; i < NUM_CTX; i++) begin
                slot_state[i] <= FREE;
                slot_zr[i]    <= '0;
                slot_zi[i]    <= '0;
                slot_cr[i]    <= '0;
                slot_ci[i]    <= '0;
                slot_iter[i]  <= '0;
                slot_imax[i]  <= '0;
                slot_esc[i]   <= 1'b0;
                slot_xpix[i]  <= '0;
                slot_ypix[i]  <= '0;
            end
        end else if (clear) begin
            ptr         <= '0;
            out_valid   <= 1'b0;
            out_iter    <= '0;
            out_escaped <= 1'b0;
            out_xpix    <= '0;
            out_ypix    <= '0;
            for (int i = 0; i < NUM_CTX; i++) begin
                slot_state[i] <= FREE;
            end
        end else begin
            ptr <= ptr + CTX_W'(1);

            if (xfer) begin
                out_valid       <= 1'b1;
                out_iter        <= slot_iter[ptr];
                out_escaped     <= slot_esc[ptr];
                out_xpix        <= slot_xpix[ptr];
                out_ypix        <= slot_ypix[ptr];
                slot_state[ptr] <= FREE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (load) begin
                slot_state[ptr] <= RUN;
                slot_zr[ptr]    <= '0;
                slot_zi[ptr]    <= '0;
                slot_iter[ptr]  <= '0;
                slot_cr[ptr]    <= in_cr;
                slot_ci[ptr]    <= in_ci;
                slot_imax[ptr]  <= iter_max;
                slot_xpix[ptr]  <= in_xpix;
                slot_ypix[ptr]  <= in_ypix;
            end

            if (s1_vld) begin
                if (wb_done) begin
                    slot_state[s1_idx] <= DONE;
                    slot_esc[s1_idx]   <= wb_escaped;
                end else begin
                    slot_zr[s1_idx]   <= wb_zr;
                    slot_zi[s1_idx]   <= wb_zi;
                    slot_iter[s1_idx] <= wb_iter;
                end
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_ctx_engine.sv
// Scoreboard bench for mandelbrot_ctx_engine: loads push expected results, a negedge monitor matches by tag.
module tb_mandelbrot_ctx_engine;

    localparam int DW  = 25;
    localparam int FW  = 20;
    localparam int IW  = 8;
    localparam int PW  = 10;
    localparam int NC  = 4;
    localparam int ONE = 1 << FW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [IW-1:0] iter_max;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_cr;
    logic [DW-1:0] in_ci;
    logic [PW-1:0] in_xpix;
    logic [PW-1:0] in_ypix;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_iter;
    logic          out_escaped;
    logic [PW-1:0] out_xpix;
    logic [PW-1:0] out_ypix;
    logic          busy;

    typedef struct {
        int x;
        int y;
        int it;
        int esc;
        int load_cyc;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   seen_tags[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mandelbrot_ctx_engine #(
        .DATA_WIDTH  (DW),
        .FRACT_WIDTH (FW),
        .ITER_WIDTH  (IW),
        .PIXEL_WIDTH (PW),
        .NUM_CTX     (NC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .iter_max    (iter_max),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cr       (in_cr),
        .in_ci       (in_ci),
        .in_xpix     (in_xpix),
        .in_ypix     (in_ypix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_iter    (out_iter),
        .out_escaped (out_escaped),
        .out_xpix    (out_xpix),
        .out_ypix    (out_ypix),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        int idx;
        idx = -1;
        if (!reset && out_valid && out_ready) begin
            foreach (sb[i]) begin
                if (idx < 0 && sb[i].x == int'(out_xpix) && sb[i].y == int'(out_ypix)) idx = i;
            end
            check($sformatf("out_tag_known(%0d,%0d)", out_xpix, out_ypix), idx >= 0, 1);
            if (idx >= 0) begin
                check($sformatf("out_iter(%0d,%0d)", out_xpix, out_ypix), out_iter, sb[idx].it);
                check($sformatf("out_escaped(%0d,%0d)", out_xpix, out_ypix), out_escaped, sb[idx].esc);
                if (sb[idx].lat >= 0)
                    check($sformatf("latency(%0d,%0d)", out_xpix, out_ypix),
                          cyc - sb[idx].load_cyc, sb[idx].lat);
                seen_tags.push_back(int'(out_xpix) * 1024 + int'(out_ypix));
                sb.delete(idx);
            end
        end
    end

    // Caller sits just after a posedge; returns just after the posedge that took the handshake.
    task automatic load_pixel(input int cr, input int ci, input int x, input int y,
                              input int imax, input int exp_it, input int exp_esc, input int lat);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        in_cr    = DW'(cr);
        in_ci    = DW'(ci);
        in_xpix  = PW'(x);
        in_ypix  = PW'(y);
        iter_max = IW'(imax);
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 200) break;
            n++;
        end
        if (in_ready) begin
            e.x = x; e.y = y; e.it = exp_it; e.esc = exp_esc; e.load_cyc = cyc; e.lat = lat;
            sb.push_back(e);
        end else begin
            check($sformatf("load_timeout(%0d,%0d)", x, y), 0, 1);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int bad_rdy;
        int bad_vld;
        int bad_stable;
        logic [IW-1:0] h_iter;
        logic [PW-1:0] h_x;
        logic [PW-1:0] h_y;
        logic          h_esc;

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        iter_max = '0; in_cr = '0; in_ci = '0; in_xpix = '0; in_ypix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_iter", out_iter, 0);
        check("rst_out_xpix", out_xpix, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single pixels: early escape, bounded run, iter_max=0, and |z|^2 == 4 boundary
        load_pixel(3 * ONE, 0, 1, 1, 10, 1, 1, 13);  wait_drain(60);
        load_pixel(0, 0, 2, 1, 10, 10, 0, 49);       wait_drain(100);
        load_pixel(0, 0, 2, 2, 0, 0, 0, 9);          wait_drain(60);
        load_pixel(2 * ONE, 0, 3, 1, 20, 2, 1, 17);  wait_drain(60);

        // Four slots filled back to back
        base = seen_tags.size();
        load_pixel(0, 0, 4, 1, 15, 15, 0, 69);
        load_pixel(3 * ONE, 0, 4, 2, 15, 1, 1, 13);
        load_pixel(-2 * ONE, 0, 4, 3, 15, 15, 0, 69);
        load_pixel(ONE / 4, ONE / 2, 4, 4, 15, 15, 0, 69);
        bad_rdy = 0;
        repeat (NC) begin
            @(negedge clk);
            if (in_ready) bad_rdy++;
        end
        check("full_in_ready_low", bad_rdy, 0);
        @(posedge clk);
        #1;
        wait_drain(120);
        check("first_out_is_3_0", (seen_tags.size() > base) ? seen_tags[base] : -1, 4 * 1024 + 2);

        // Output stalled with every slot finished
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) load_pixel(3 * ONE, 0, 5, k, 5, 1, 1, -1);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_out_valid", out_valid, 1);
        h_iter = out_iter; h_x = out_xpix; h_y = out_ypix; h_esc = out_escaped;
        bad_rdy = 0; bad_vld = 0; bad_stable = 0;
        repeat (50) begin
            @(negedge clk);
            if (in_ready) bad_rdy++;
            if (!out_valid) bad_vld++;
            if (out_iter != h_iter || out_xpix != h_x || out_ypix != h_y || out_escaped != h_esc)
                bad_stable++;
        end
        check("stall_in_ready_low", bad_rdy, 0);
        check("stall_valid_held", bad_vld, 0);
        check("stall_out_stable", bad_stable, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain(8);

        // Sync clear with three slots running and a held result
        out_ready = 1'b0;
        load_pixel(3 * ONE, 0, 6, 0, 5, 1, 1, -1);
        for (int k = 1; k < 4; k++) load_pixel(0, 0, 6, k, 200, 200, 0, -1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pre_clear_out_valid", out_valid, 1);
        check("pre_clear_busy", busy, 1);
        @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("clear_in_ready", in_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        sb.delete();
        @(negedge clk);
        check("clear_out_valid", out_valid, 0);
        check("clear_busy", busy, 0);
        check("clear_out_iter", out_iter, 0);
        out_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        load_pixel(3 * ONE, 0, 7, 0, 5, 1, 1, 13);
        wait_drain(40);

        // Async reset with the same occupancy
        out_ready = 1'b0;
        load_pixel(3 * ONE, 0, 8, 0, 5, 1, 1, -1);
        for (int k = 1; k < 4; k++) load_pixel(0, 0, 8, k, 200, 200, 0, -1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_out_valid", out_valid, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        load_pixel(3 * ONE, 0, 7, 1, 5, 1, 1, 13);
        wait_drain(40);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
